// File: rtl/viterbi_pkg.sv
// Shared constants and helpers for the hard-decision Viterbi decoder datapath.
package viterbi_pkg;

    // Branch metric width produced by the branch-metric units.
    localparam int unsigned BM_W     = 2;

    // Default path metric width.
    localparam int unsigned PM_W_DEF = 8;

    // Amount removed from every path metric when the global normalizer fires,
    // evaluated for the default width.
    localparam int unsigned NORM_SUB = 2 ** (PM_W_DEF - 1);

    // Normalization subtrahend for an arbitrary path metric width.
    function automatic logic [31:0] norm_sub(input int unsigned pm_w);
        return 32'd1 << (pm_w - 1);
    endfunction

    // Initial path metric: state 0 starts as the known-good state, all others
    // start a quarter of the metric range behind it.
    function automatic logic [31:0] init_metric(input int unsigned state_id,
                                                input int unsigned pm_w);
        return (state_id == 0) ? 32'd0 : (32'd1 << (pm_w - 2));
    endfunction

endpackage

// File: rtl/acs_cmp.sv
// Combinational add-compare-select core with normalization and range checks.
module acs_cmp
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W = PM_W_DEF
) (
    input  logic [BM_W-1:0] bm_0,
    input  logic [BM_W-1:0] bm_1,
    input  logic [PM_W-1:0] pm_pred0,
    input  logic [PM_W-1:0] pm_pred1,
    input  logic            norm_en,
    output logic            sel,
    output logic [PM_W-1:0] r,
    output logic            ovf,
    output logic            unf
);

    localparam logic [PM_W:0] NS = (PM_W + 1)'(norm_sub(PM_W));

    logic [PM_W:0] s0;
    logic [PM_W:0] s1;
    logic [PM_W:0] m;
    logic [PM_W:0] r_full;

    // Sums carry one extra bit so overflow is visible; ties keep predecessor 0.
    always_comb begin
        s0     = {1'b0, pm_pred0} + {{(PM_W + 1 - BM_W){1'b0}}, bm_0};
        s1     = {1'b0, pm_pred1} + {{(PM_W + 1 - BM_W){1'b0}}, bm_1};
        sel    = (s1 < s0);
        m      = sel ? s1 : s0;
        unf    = 1'b0;
        r_full = m;
        if (norm_en) begin
            if (m < NS) begin
                unf    = 1'b1;
                r_full = '0;
            end else begin
                r_full = m - NS;
            end
        end
        ovf = r_full[PM_W];
        r   = r_full[PM_W-1:0];
    end

endmodule

// File: rtl/acs_state.sv
// Registered add-compare-select node for one trellis state.
module acs_state
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W     = PM_W_DEF,
    parameter int unsigned STATE_ID = 0,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             in_valid,
    input  logic [BM_W-1:0]  bm_0,
    input  logic [BM_W-1:0]  bm_1,
    input  logic [PM_W-1:0]  pm_pred0,
    input  logic [PM_W-1:0]  pm_pred1,
    input  logic             norm_en,
    output logic [PM_W-1:0]  pm_out,
    output logic             pm_msb,
    output logic             decision,
    output logic             dec_valid,
    output logic [CNT_W-1:0] step_cnt,
    output logic             err
);

    localparam logic [PM_W-1:0] INIT = PM_W'(init_metric(STATE_ID, PM_W));

    logic            sel;
    logic [PM_W-1:0] r;
    logic            ovf;
    logic            unf;

    acs_cmp #(
        .PM_W (PM_W)
    ) u_cmp (
        .bm_0     (bm_0),
        .bm_1     (bm_1),
        .pm_pred0 (pm_pred0),
        .pm_pred1 (pm_pred1),
        .norm_en  (norm_en),
        .sel      (sel),
        .r        (r),
        .ovf      (ovf),
        .unf      (unf)
    );

    // Path metric, decision, step counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_out    <= INIT;
            decision  <= 1'b0;
            dec_valid <= 1'b0;
            step_cnt  <= '0;
            err       <= 1'b0;
        end else if (frame_start) begin
            pm_out    <= INIT;
            decision  <= 1'b0;
            dec_valid <= 1'b0;
            step_cnt  <= '0;
            err       <= 1'b0;
        end else if (in_valid) begin
            pm_out    <= ovf ? '1 : r;
            err       <= err | ovf | unf;
            decision  <= sel;
            dec_valid <= 1'b1;
            if (step_cnt != '1) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end
        end else begin
            dec_valid <= 1'b0;
        end
    end

    // Normalization request is simply the metric's top bit.
    always_comb begin
        pm_msb = pm_out[PM_W-1];
    end

endmodule

// File: tb/tb_acs_state.sv
// Self-checking bench for acs_state: vector table, corner sequences, random vs model.
module tb_acs_state;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       in_valid;
    logic [1:0] bm_0;
    logic [1:0] bm_1;
    logic [7:0] pm_pred0;
    logic [7:0] pm_pred1;
    logic       norm_en;

    logic [7:0] pm_out0, pm_out3;
    logic       pm_msb0, pm_msb3;
    logic       dec0, dec3;
    logic       dv0, dv3;
    logic [9:0] cnt0, cnt3;
    logic       err0, err3;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural reference state (plain integers).
    int m_pm, m_dec, m_dv, m_cnt, m_err;

    acs_state #(.PM_W(8), .STATE_ID(0), .CNT_W(10)) u0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
        .bm_0(bm_0), .bm_1(bm_1), .pm_pred0(pm_pred0), .pm_pred1(pm_pred1),
        .norm_en(norm_en), .pm_out(pm_out0), .pm_msb(pm_msb0), .decision(dec0),
        .dec_valid(dv0), .step_cnt(cnt0), .err(err0)
    );

    acs_state #(.PM_W(8), .STATE_ID(3), .CNT_W(10)) u3 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
        .bm_0(bm_0), .bm_1(bm_1), .pm_pred0(pm_pred0), .pm_pred1(pm_pred1),
        .norm_en(norm_en), .pm_out(pm_out3), .pm_msb(pm_msb3), .decision(dec3),
        .dec_valid(dv3), .step_cnt(cnt3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p0, b0, p1, b1, ne;
        int e_pm, e_dec, e_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic model_reset();
        m_pm = 0; m_dec = 0; m_dv = 0; m_cnt = 0; m_err = 0;
    endtask

    // Reference: next state derived directly from the step rules.
    task automatic model_step(input int fs, input int iv, input int p0, input int b0,
                              input int p1, input int b1, input int ne);
        int s0, s1, mm, sel, r;
        if (fs != 0) begin
            model_reset();
        end else if (iv != 0) begin
            s0 = p0 + b0;
            s1 = p1 + b1;
            if (s1 < s0) begin mm = s1; sel = 1; end
            else begin mm = s0; sel = 0; end
            r = mm;
            if (ne != 0) begin
                if (mm < 128) begin r = 0; m_err = 1; end
                else r = mm - 128;
            end
            if (r > 255) begin m_pm = 255; m_err = 1; end
            else m_pm = r;
            m_dec = sel;
            m_dv  = 1;
            m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
        end else begin
            m_dv = 0;
        end
    endtask

    task automatic cycle(input int fs, input int iv, input int p0, input int b0,
                         input int p1, input int b1, input int ne);
        @(negedge clk);
        frame_start = fs[0];
        in_valid    = iv[0];
        pm_pred0    = p0[7:0];
        bm_0        = b0[1:0];
        pm_pred1    = p1[7:0];
        bm_1        = b1[1:0];
        norm_en     = ne[0];
        model_step(fs, iv, p0, b0, p1, b1, ne);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pm"},  int'(pm_out0), m_pm);
        check({tag, ".msb"}, int'(pm_msb0), (m_pm >= 128) ? 1 : 0);
        check({tag, ".dec"}, int'(dec0), m_dec);
        check({tag, ".dv"},  int'(dv0), m_dv);
        check({tag, ".cnt"}, int'(cnt0), m_cnt);
        check({tag, ".err"}, int'(err0), m_err);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".pm0"},  int'(pm_out0), 0);
        check({tag, ".pm3"},  int'(pm_out3), 64);
        check({tag, ".dec"},  int'(dec0) + int'(dec3), 0);
        check({tag, ".dv"},   int'(dv0) + int'(dv3), 0);
        check({tag, ".cnt"},  int'(cnt0) + int'(cnt3), 0);
        check({tag, ".err"},  int'(err0) + int'(err3), 0);
        check({tag, ".msb"},  int'(pm_msb0) + int'(pm_msb3), 0);
    endtask

    initial begin
        vecs[0] = '{10, 2, 9, 0, 0, 9, 1, 0};
        vecs[1] = '{5, 1, 6, 0, 0, 6, 0, 0};
        vecs[2] = '{200, 1, 210, 0, 1, 73, 0, 0};
        vecs[3] = '{255, 2, 255, 3, 0, 255, 0, 1};
        vecs[4] = '{50, 0, 60, 0, 1, 0, 0, 1};

        rst_n = 1'b1; frame_start = 1'b0; in_valid = 1'b0; norm_en = 1'b0;
        bm_0 = '0; bm_1 = '0; pm_pred0 = '0; pm_pred1 = '0;
        #3 rst_n = 1'b0;
        #4;
        check_reset_vals("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // First step, then idle cycle holds the metric and drops dec_valid.
        cycle(0, 1, 10, 2, 9, 0, 0);
        check("step1.pm", int'(pm_out0), 9);
        check("step1.dec", int'(dec0), 1);
        check("step1.dv", int'(dv0), 1);
        check("step1.cnt", int'(cnt0), 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("idle.dv", int'(dv0), 0);
        check("idle.pm", int'(pm_out0), 9);
        check_model("idle");

        // Table: each vector on a freshly started frame.
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
            cycle(0, 1, vecs[i].p0, vecs[i].b0, vecs[i].p1, vecs[i].b1, vecs[i].ne);
            check($sformatf("vec%0d.pm", i), int'(pm_out0), vecs[i].e_pm);
            check($sformatf("vec%0d.dec", i), int'(dec0), vecs[i].e_dec);
            check($sformatf("vec%0d.err", i), int'(err0), vecs[i].e_err);
        end

        // Overflow, clean step keeps err sticky, frame_start with in_valid clears.
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 255, 2, 255, 3, 0);
        check("ovf.pm", int'(pm_out0), 255);
        check("ovf.err", int'(err0), 1);
        cycle(0, 1, 20, 1, 30, 0, 0);
        check("sticky.pm", int'(pm_out0), 21);
        check("sticky.err", int'(err0), 1);
        cycle(1, 1, 3, 0, 4, 0, 0);
        check("fs.pm", int'(pm_out0), 0);
        check("fs.err", int'(err0), 0);
        check("fs.cnt", int'(cnt0), 0);
        check("fs.dv", int'(dv0), 0);

        // Counter saturation.
        for (int i = 0; i < 1028; i++) begin
            cycle(0, 1, i % 256, i % 4, (i * 7) % 256, (i + 1) % 4, 0);
            if (i == 1021) check("sat.pre", int'(cnt0), 1022);
        end
        check("sat.cnt", int'(cnt0), 1023);
        check_model("sat");

        // Asynchronous reset in the middle of a step.
        @(negedge clk);
        in_valid = 1'b1; pm_pred0 = 8'd100; bm_0 = 2'd1; pm_pred1 = 8'd90; bm_1 = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("areset");
        @(posedge clk);
        #1;
        check_reset_vals("areset_hold");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0) ? 1 : 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
